// File: rtl/window_increase_counter_if.sv
// Sample-stream port bundle for window_increase_counter.
// The producer side is master; the counter is slave.
interface window_increase_counter_if #(
  parameter int DATA_W  = 16,
  parameter int MAX_WIN = 8,
  parameter int CNT_W   = 16
);
  localparam int LEN_W = $clog2(MAX_WIN + 1);
  localparam int SUM_W = DATA_W + $clog2(MAX_WIN);

  logic              clear;
  logic [LEN_W-1:0]  win_len;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  count;
  logic              count_sat;
  logic [CNT_W-1:0]  n_samples;
  logic [SUM_W-1:0]  window_sum;
  logic              sum_valid;

  modport master (
    output clear, win_len, in_valid, in_data,
    input  count, count_sat, n_samples, window_sum, sum_valid
  );

  modport slave (
    input  clear, win_len, in_valid, in_data,
    output count, count_sat, n_samples, window_sum, sum_valid
  );
endinterface

// File: rtl/window_increase_counter.sv
// Sliding-window increase counter: counts samples whose L-window sum beats the previous one.
// The increase test compares the new sample against the one leaving the window (x_k > x_(k-L)).

module window_increase_counter_cell #(
  parameter int DATA_W = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     q <= '0;
    else if (clear) q <= '0;
    else if (shift) q <= d;
  end
endmodule

module window_increase_counter #(
  parameter int DATA_W  = 16,
  parameter int MAX_WIN = 8,
  parameter int CNT_W   = 16
)(
  input logic clk,
  input logic rst_n,
  window_increase_counter_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_WIN + 1);
  localparam int SUM_W = DATA_W + $clog2(MAX_WIN);
  localparam int CMP_W = (CNT_W > LEN_W) ? CNT_W : LEN_W;

  logic [LEN_W-1:0]               l_reg, l_next;
  logic [MAX_WIN-1:0][DATA_W-1:0] hist, hist_d;
  logic [DATA_W-1:0]              leaving;
  logic [CNT_W-1:0]               count_q, n_q, n_next;
  logic [SUM_W-1:0]               sum_q, sum_next;
  logic                           count_sat_q, sum_valid_q;
  logic                           accept, full, inc, full_next;

  assign accept = bus.in_valid & ~bus.clear;

  always_comb begin
    l_next = bus.win_len;
    if (bus.win_len == '0)                     l_next = LEN_W'(1);
    else if (bus.win_len > LEN_W'(MAX_WIN))    l_next = LEN_W'(MAX_WIN);
  end

  // history: h[0] newest, one cell per entry, shifts only on accepted samples
  for (genvar i = 0; i < MAX_WIN; i++) begin : g_hist
    if (i == 0) begin : g_head
      assign hist_d[i] = bus.in_data;
    end else begin : g_tail
      assign hist_d[i] = hist[i-1];
    end
    window_increase_counter_cell #(.DATA_W(DATA_W)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.clear),
      .shift (accept),
      .d     (hist_d[i]),
      .q     (hist[i])
    );
  end

  // sample leaving the window is h[L-1]; entries beyond L are ignored
  always_comb begin
    leaving = '0;
    for (int i = 0; i < MAX_WIN; i++)
      if (l_reg == LEN_W'(i + 1)) leaving = hist[i];
  end

  assign full      = CMP_W'(n_q) >= CMP_W'(l_reg);
  assign inc       = accept & full & (bus.in_data > leaving);
  assign n_next    = (&n_q) ? n_q : n_q + CNT_W'(1);
  assign full_next = CMP_W'(n_next) >= CMP_W'(l_reg);
  assign sum_next  = sum_q + SUM_W'(bus.in_data) - (full ? SUM_W'(leaving) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_reg       <= LEN_W'(1);
      count_q     <= '0;
      count_sat_q <= 1'b0;
      n_q         <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else if (bus.clear) begin
      l_reg       <= l_next;
      count_q     <= '0;
      count_sat_q <= 1'b0;
      n_q         <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else if (accept) begin
      n_q         <= n_next;
      sum_q       <= sum_next;
      sum_valid_q <= full_next;
      if (inc) begin
        if (&count_q) count_sat_q <= 1'b1;
        else          count_q     <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.count      = count_q;
  assign bus.count_sat  = count_sat_q;
  assign bus.n_samples  = n_q;
  assign bus.window_sum = sum_q;
  assign bus.sum_valid  = sum_valid_q;
endmodule

// File: tb/tb_window_increase_counter.sv
// Bench for window_increase_counter: vector table, directed corner sequences,
// and random traffic checked against a queue-based window-sum reference.
module tb_window_increase_counter;
  localparam int DW   = 16;
  localparam int MAXW = 8;
  localparam int LW   = $clog2(MAXW + 1);
  localparam longint unsigned CMAX = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_increase_counter_if #(.DATA_W(DW), .MAX_WIN(MAXW), .CNT_W(16)) bus0 ();
  window_increase_counter_if #(.DATA_W(DW), .MAX_WIN(MAXW), .CNT_W(4))  bus1 ();

  window_increase_counter #(.DATA_W(DW), .MAX_WIN(MAXW), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  window_increase_counter #(.DATA_W(DW), .MAX_WIN(MAXW), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  // reference: accepted samples in a queue, window sums recomputed from scratch
  int unsigned     q[$];
  int              L_m;
  longint          n_m;
  longint unsigned cnt_m;
  bit              sat_m;

  typedef struct {
    logic clr; int wl; logic v; int d;
    int e_cnt; int e_n; int e_sum; logic e_sv;
  } vec_t;
  vec_t tbl[11];

  int stream[10] = '{199, 200, 208, 210, 200, 207, 240, 269, 260, 263};
  int l1cnt[10]  = '{0, 1, 2, 3, 3, 4, 5, 6, 6, 7};
  int cstream[12] = '{5, 9, 2, 7, 7, 1, 3, 8, 6, 4, 9, 9};

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint wsum();
    longint s = 0;
    int k = (q.size() < L_m) ? q.size() : L_m;
    for (int i = 0; i < k; i++) s += longint'(q[q.size() - 1 - i]);
    return s;
  endfunction

  task automatic model_reset();
    q.delete(); n_m = 0; cnt_m = 0; sat_m = 0; L_m = 1;
  endtask

  task automatic model_upd(input logic clr, input int wl, input logic v, input int d);
    bit     had_full;
    longint prev;
    if (clr) begin
      q.delete(); n_m = 0; cnt_m = 0; sat_m = 0;
      L_m = (wl == 0) ? 1 : ((wl > MAXW) ? MAXW : wl);
    end else if (v) begin
      had_full = (n_m >= L_m);
      prev = wsum();
      q.push_back(d);
      if (q.size() > MAXW) void'(q.pop_front());
      n_m++;
      if (had_full && wsum() > prev) begin
        if (cnt_m == CMAX) sat_m = 1;
        else               cnt_m++;
      end
    end
  endtask

  task automatic check0();
    chk("count",      bus0.count,      cnt_m);
    chk("count_sat",  bus0.count_sat,  sat_m);
    chk("n_samples",  bus0.n_samples,  (n_m > CMAX) ? CMAX : n_m);
    chk("window_sum", bus0.window_sum, wsum());
    chk("sum_valid",  bus0.sum_valid,  n_m >= L_m);
  endtask

  // inputs change while clk is low; outputs sampled on the falling edge
  task automatic step0(input logic clr, input int wl, input logic v, input int d);
    bus0.clear = clr; bus0.win_len = LW'(wl); bus0.in_valid = v; bus0.in_data = DW'(d);
    @(posedge clk);
    model_upd(clr, wl, v, d);
    @(negedge clk);
    bus0.clear = 1'b0; bus0.in_valid = 1'b0;
    check0();
  endtask

  task automatic step1(input logic clr, input int wl, input logic v, input int d);
    bus1.clear = clr; bus1.win_len = LW'(wl); bus1.in_valid = v; bus1.in_data = DW'(d);
    @(posedge clk);
    @(negedge clk);
    bus1.clear = 1'b0; bus1.in_valid = 1'b0;
  endtask

  task automatic play_stream(input bit gaps);
    for (int i = 0; i < 10; i++) begin
      if (gaps) for (int g = $urandom_range(0, 3); g > 0; g--) step0(0, 0, 0, 0);
      step0(0, 0, 1, stream[i]);
    end
  endtask

  initial begin
    bus0.clear = 0; bus0.win_len = '0; bus0.in_valid = 0; bus0.in_data = '0;
    bus1.clear = 0; bus1.win_len = '0; bus1.in_valid = 0; bus1.in_data = '0;
    model_reset();

    // reset state
    #12;
    check0();
    chk("rst_small_count", bus1.count, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // vector table: clear with L=1, then the reference stream back-to-back
    tbl[0] = '{clr:1, wl:1, v:0, d:0, e_cnt:0, e_n:0, e_sum:0, e_sv:0};
    for (int i = 0; i < 10; i++)
      tbl[i+1] = '{clr:0, wl:0, v:1, d:stream[i], e_cnt:l1cnt[i], e_n:i+1, e_sum:stream[i], e_sv:1};
    for (int i = 0; i < 11; i++) begin
      bus0.clear = tbl[i].clr; bus0.win_len = LW'(tbl[i].wl);
      bus0.in_valid = tbl[i].v; bus0.in_data = DW'(tbl[i].d);
      @(posedge clk);
      model_upd(tbl[i].clr, tbl[i].wl, tbl[i].v, tbl[i].d);
      @(negedge clk);
      bus0.clear = 1'b0; bus0.in_valid = 1'b0;
      chk("tbl_count", bus0.count,      tbl[i].e_cnt);
      chk("tbl_n",     bus0.n_samples,  tbl[i].e_n);
      chk("tbl_sum",   bus0.window_sum, tbl[i].e_sum);
      chk("tbl_sv",    bus0.sum_valid,  tbl[i].e_sv);
    end

    // L=3 with random gaps
    step0(1, 3, 0, 0);
    step0(0, 0, 1, stream[0]);
    step0(0, 0, 0, 0);
    step0(0, 0, 1, stream[1]);
    chk("l3_sv_after2", bus0.sum_valid, 0);
    step0(0, 0, 1, stream[2]);
    chk("l3_sum_after3", bus0.window_sum, 607);
    chk("l3_sv_after3",  bus0.sum_valid, 1);
    for (int i = 3; i < 10; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step0(0, 0, 0, 0);
      step0(0, 0, 1, stream[i]);
    end
    chk("l3_count", bus0.count, 5);
    chk("l3_sum_end", bus0.window_sum, 792);

    // saturation on the 4-bit counter instance
    step1(1, 1, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      step1(0, 0, 1, 100 + j);
      chk("sat_count", bus1.count,     (j - 1 > 15) ? 15 : j - 1);
      chk("sat_flag",  bus1.count_sat, j >= 17);
      chk("sat_n",     bus1.n_samples, (j > 15) ? 15 : j);
    end

    // clamp: win_len=0 acts as L=1
    step0(1, 0, 0, 0);
    play_stream(0);
    chk("clamp0_count", bus0.count, 7);

    // clamp: win_len above MAX_WIN acts as L=MAX_WIN
    step0(1, MAXW + 3, 0, 0);
    for (int i = 0; i < 12; i++) begin
      step0(0, 0, 1, cstream[i]);
      if (i == 6) chk("clampmax_sv7", bus0.sum_valid, 0);
      if (i == 7) begin
        chk("clampmax_sum8", bus0.window_sum, 42);
        chk("clampmax_cnt8", bus0.count, 0);
      end
      if (i == 8) begin
        chk("clampmax_sum9", bus0.window_sum, 43);
        chk("clampmax_cnt9", bus0.count, 1);
      end
    end

    // clear beats in_valid in the same cycle
    step0(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step0(0, 0, 1, stream[i]);
    step0(1, 3, 1, 500);
    chk("clrv_count", bus0.count, 0);
    chk("clrv_n",     bus0.n_samples, 0);
    chk("clrv_sum",   bus0.window_sum, 0);
    chk("clrv_sv",    bus0.sum_valid, 0);
    play_stream(0);
    chk("clrv_replay_count", bus0.count, 5);

    // asynchronous reset mid-stream, between edges
    step0(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) step0(0, 0, 1, stream[i]);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_count", bus0.count, 0);
    chk("arst_n",     bus0.n_samples, 0);
    chk("arst_sum",   bus0.window_sum, 0);
    chk("arst_sv",    bus0.sum_valid, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    step0(0, 0, 1, stream[0]);
    chk("arst_L1_sv", bus0.sum_valid, 1);
    for (int i = 1; i < 10; i++) step0(0, 0, 1, stream[i]);
    chk("arst_replay_count", bus0.count, 7);

    // random traffic: gaps, ties, large values, occasional clear
    for (int c = 0; c < 400; c++) begin
      int r;
      int d;
      r = $urandom_range(0, 99);
      d = ($urandom_range(0, 3) == 0) ? 65535 - $urandom_range(0, 3) : $urandom_range(0, 20);
      if (r < 4) step0(1, $urandom_range(0, 15), $urandom_range(0, 1), d);
      else       step0(0, $urandom_range(0, 15), r >= 30, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/window_increase_counter.md
# window_increase_counter

Parametrised sliding-window increase counter for sample streams, the successor to the fixed-width depth-sweep counters. It accepts one sample per valid cycle. For a run-time selectable window length L, it counts how many accepted samples make the L-sample window sum strictly greater than the previous window sum, and it exposes the current window sum. It sits directly behind the puzzle input parser and feeds the result register bank.

## Interface
- DATA_W, 16, sample width (unsigned)
- MAX_WIN, 8, maximum window length; history depth; must be >= 1
- CNT_W, 16, width of increase and sample counters
- Derived, not overridable: LEN_W = $clog2(MAX_WIN+1); SUM_W = DATA_W + $clog2(MAX_WIN)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous restart; zeroes state and latches win_len
- win_len  in  LEN_W  requested window length; sampled only on clear
- in_valid  in  1  in_data accepted on this edge when high
- in_data  in  DATA_W  sample value, unsigned
- count  out  CNT_W  number of window-sum increases since reset/clear
- count_sat  out  1  sticky; count has saturated
- n_samples  out  CNT_W  accepted samples since reset/clear, saturating
- window_sum  out  SUM_W  sum of last L accepted samples
- sum_valid  out  1  high once >= L samples accepted

## Operation
- Active window length L is a register.
  - Reset value: 1.
  - On clear, L loads win_len, with two clamps: 0 becomes 1, and a value above MAX_WIN becomes MAX_WIN.
- History is a MAX_WIN-entry shift register, h[0] newest.
  - Shifts only on an accepted sample (in_valid=1, clear=0).
  - Entries beyond L are kept but ignored.
- Increase test uses the exact identity sum_k > sum_(k-1) iff x_k > x_(k-L).
  - No sum subtraction is used for the test.
  - On an accepted sample, compare in_data against h[L-1] (the sample leaving the window), unsigned, strict >.
  - The test is qualified only when n_samples >= L before this sample, i.e. a previous full window exists.
- count increments by 1 on each qualified increase.
  - Saturates at 2^CNT_W-1.
  - count_sat is set when an increment is requested while count is all ones.
- n_samples increments on each accepted sample and saturates at all ones; qualification still holds once saturated.
- window_sum update on an accepted sample:
  - window_sum += in_data.
  - Also window_sum -= h[L-1], only when n_samples >= L.
  - Modular in SUM_W, which cannot overflow by construction.
- sum_valid = (n_samples >= L), registered.
- clear has priority over in_valid in the same cycle. The sample is dropped, and these are zeroed: history, count, count_sat, n_samples, window_sum, sum_valid.
- Idle cycles (in_valid=0) change nothing; gaps between samples are legal and of any length.

## Timing
- Reset values (rst_n low, asynchronous): count=0, count_sat=0, n_samples=0, window_sum=0, sum_valid=0, history all 0, L=1.
- Reset release is synchronised externally; first edge with rst_n high may accept a sample.
- Latency: sample accepted at edge k is reflected in count, n_samples, window_sum and sum_valid immediately after edge k (1-cycle registered).
- Back-to-back samples are accepted every cycle; there is no backpressure.
- clear at edge k: all outputs zero after edge k, with the new L. A sample at edge k+1 is the first of the new stream.
- win_len changes without clear have no effect.
- rst_n asserted mid-stream: outputs go to reset values asynchronously; no partial update completes.

## Test plan
- Reset, clear with win_len=1, then stream 199,200,208,210,200,207,240,269,260,263 back-to-back.
  - Required: count=7, n_samples=10, window_sum=263, sum_valid=1.
- Clear with win_len=3, same stream with random 0-3 cycle gaps.
  - Required: count=5.
  - window_sum=607 after the 3rd sample; sum_valid rises after the 3rd sample.
  - window_sum=792 at the end.
- CNT_W=4, L=1, strictly increasing stream of 20 samples.
  - Required: count sticks at 15, count_sat=1 after the 17th sample, n_samples=15.
- Clamping:
  - win_len=0 must behave as L=1 on the first stream: count=7.
  - win_len=MAX_WIN+3 must behave as L=MAX_WIN: sum of first MAX_WIN samples, then the first qualified compare on sample MAX_WIN+1.
- clear asserted together with in_valid mid-stream (value 500) at L=3.
  - Required: all outputs 0 next cycle, 500 not counted.
  - Replaying the 10-sample stream gives count=5.
- rst_n pulsed low between clock edges after 5 samples.
  - Required: outputs zero before the next edge and L=1.
  - Replaying the stream gives count=7.
